// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: shared types and constants for the JK bank driver.
//   state_t     - controller states
//   RSP_*       - response codes reported on rsp_code
//   MODE_*      - command modes carried on cmd_mode
package jk_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    RESP
  } state_t;

  localparam logic [1:0] RSP_OK              = 2'b00;
  localparam logic [1:0] RSP_RETRY_EXHAUSTED = 2'b01;
  localparam logic [1:0] RSP_QN_BAD          = 2'b10;

  localparam logic MODE_LOAD   = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

endpackage

// File: rtl/jk_excite.sv
// jk_excite: combinational J/K excitation for one drive attempt.
//   i_q          current bank Q
//   i_expected   target Q after the drive (load rule)
//   i_mask       toggle mask (toggle rule)
//   i_use_toggle 1 = toggle rule (J=K=mask), 0 = load rule
//   o_j, o_k     J/K values to present to the bank
module jk_excite
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_expected,
  input  logic [WIDTH-1:0] i_mask,
  input  logic             i_use_toggle,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k
);

  // Load rule only excites bits that differ, so J and K are never both set.
  assign o_j = i_use_toggle ? i_mask : (i_expected & ~i_q);
  assign o_k = i_use_toggle ? i_mask : (~i_expected & i_q);

endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: write-side controller for an external JK flip-flop bank.
// Accepts LOAD/TOGGLE commands, drives J/K for one cycle per attempt, waits
// for the bank to settle, verifies Q/Qn, retries on mismatch, then responds.
//   clk, rst             clock, synchronous active-high reset
//   cmd_valid/ready      command handshake (ready only in IDLE)
//   cmd_mode, cmd_data   0=LOAD data, 1=TOGGLE bits in data
//   jk_j, jk_k           registered J/K to the bank, zero outside DRIVE
//   jk_q, jk_qn          bank feedback
//   rsp_valid/ready      response handshake, held until consumed
//   rsp_code, rsp_q      result code and Q sampled at final compare
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// DRIVE  | J/K presented to the bank for one cycle
// SETTLE | J=K=0 for SETTLE_CYCLES before comparing
// CHECK  | compare Q/Qn, choose OK / retry / error
// RESP   | response held until rsp_ready
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] jk_q,
  input  logic [WIDTH-1:0] jk_qn,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_code,
  output logic [WIDTH-1:0] rsp_q
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_exp;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_rsp_q;
  logic [1:0]       r_rsp_code;
  logic             r_rsp_valid;
  logic             r_ready;
  logic [3:0]       r_retry;
  logic [SW-1:0]    r_settle;

  logic [WIDTH-1:0] w_first_exp;
  logic [WIDTH-1:0] w_exc_exp;
  logic             w_in_idle;
  logic             w_use_toggle;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_qn_bad;
  logic             w_match;

  assign w_first_exp  = (cmd_mode == MODE_TOGGLE) ? (jk_q ^ cmd_data) : cmd_data;
  assign w_in_idle    = (r_state == IDLE);
  // J/K are registered, so they are computed at the edge that enters DRIVE.
  // The bank holds between that edge and the DRIVE cycle, so jk_q is current.
  assign w_exc_exp    = w_in_idle ? w_first_exp : r_exp;
  assign w_use_toggle = w_in_idle && (cmd_mode == MODE_TOGGLE);
  assign w_qn_bad     = (jk_qn != ~jk_q);
  assign w_match      = (jk_q == r_exp);

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .i_q          (jk_q),
    .i_expected   (w_exc_exp),
    .i_mask       (cmd_data),
    .i_use_toggle (w_use_toggle),
    .o_j          (w_j),
    .o_k          (w_k)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_exp       <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_rsp_q     <= '0;
      r_rsp_code  <= RSP_OK;
      r_rsp_valid <= 1'b0;
      r_ready     <= 1'b0;
      r_retry     <= '0;
      r_settle    <= '0;
    end else begin
      r_j <= '0;
      r_k <= '0;
      unique case (r_state)
        IDLE: begin
          if (r_ready && cmd_valid) begin
            r_exp   <= w_first_exp;
            r_j     <= w_j;
            r_k     <= w_k;
            r_ready <= 1'b0;
            r_retry <= '0;
            r_state <= DRIVE;
          end else begin
            r_ready <= 1'b1;
          end
        end
        DRIVE: begin
          r_settle <= SW'(SETTLE_CYCLES - 1);
          r_state  <= SETTLE;
        end
        SETTLE: begin
          if (r_settle == '0) begin
            r_state <= CHECK;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        CHECK: begin
          r_rsp_q <= jk_q;
          if (w_qn_bad) begin
            r_rsp_code  <= RSP_QN_BAD;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (w_match) begin
            r_rsp_code  <= RSP_OK;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else if (r_retry < 4'(MAX_RETRY)) begin
            r_retry <= (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
            r_j     <= w_j;
            r_k     <= w_k;
            r_state <= DRIVE;
          end else begin
            r_rsp_code  <= RSP_RETRY_EXHAUSTED;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_retry     <= '0;
            r_ready     <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign jk_j      = r_j;
  assign jk_k      = r_k;
  assign rsp_valid = r_rsp_valid;
  assign rsp_code  = r_rsp_code;
  assign rsp_q     = r_rsp_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: behavioural JK bank with stuck-at-0 and Qn fault
// hooks, plus a transaction-level model predicting drives, code and final Q.
module tb_jk_bank_driver;

  localparam int W  = 8;
  localparam int S  = 1;
  localparam int MR = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_mode;
  logic [W-1:0] cmd_data;
  logic [W-1:0] jk_j;
  logic [W-1:0] jk_k;
  logic [W-1:0] jk_q;
  logic [W-1:0] jk_qn;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_code;
  logic [W-1:0] rsp_q;

  int tests = 0;
  int fails = 0;

  // bank model and fault hooks
  logic [W-1:0] bank_q;
  logic         bank_clr;
  logic [W-1:0] stuck0;
  logic         qn_arm;
  logic         qn_force;

  // model state and prediction scratch
  logic [W-1:0] pred_q;
  logic [W-1:0] pj [16];
  logic [W-1:0] pk [16];
  logic [W-1:0] last_q;
  logic [1:0]   last_code;
  int           last_ndrv;
  logic [W-1:0] first_j;
  logic [W-1:0] first_k;
  logic [W-1:0] last_j;

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(W), .SETTLE_CYCLES(S), .MAX_RETRY(MR)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_data  (cmd_data),
    .jk_j      (jk_j),
    .jk_k      (jk_k),
    .jk_q      (jk_q),
    .jk_qn     (jk_qn),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_code  (rsp_code),
    .rsp_q     (rsp_q)
  );

  // JK characteristic equation; stuck bits read back as 0. With qn_arm set,
  // the first non-zero drive collapses Q to 0 and Qn follows Q.
  always @(posedge clk) begin
    if (!qn_arm) qn_force <= 1'b0;
    if (bank_clr) begin
      bank_q <= '0;
    end else if (qn_arm && ((jk_j | jk_k) != '0)) begin
      qn_force <= 1'b1;
      bank_q   <= '0;
    end else begin
      bank_q <= ((jk_j & ~bank_q) | (~jk_k & bank_q)) & ~stuck0;
    end
  end

  assign jk_q  = bank_q;
  assign jk_qn = qn_force ? bank_q : ~bank_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level prediction: attempts, response code, final Q, J/K per drive.
  task automatic predict(input logic [W-1:0] q0, input logic mode, input logic [W-1:0] data,
                         input logic [W-1:0] stuck, input logic qnf,
                         output int n, output logic [1:0] code, output logic [W-1:0] qf);
    logic [W-1:0] tgt, q, j, k;
    tgt  = mode ? (q0 ^ data) : data;
    q    = q0;
    n    = 0;
    code = 2'b00;
    for (int i = 0; i <= MR; i++) begin
      if (i == 0 && mode) begin
        j = data;
        k = data;
      end else begin
        j = tgt & ~q;
        k = ~tgt & q;
      end
      pj[i] = j;
      pk[i] = k;
      n = i + 1;
      if (qnf && ((j | k) != '0)) begin
        q    = '0;
        code = 2'b10;
        break;
      end
      q = ((j & ~q) | (~k & q)) & ~stuck;
      if (q == tgt) begin
        code = 2'b00;
        break;
      end
      if (i == MR) code = 2'b01;
    end
    qf = q;
  endtask

  // Runs one command from a negedge where cmd_ready is expected high, checking
  // every cycle until the response handshake; returns at the negedge after it.
  task automatic run_txn(input logic mode, input logic [W-1:0] data, input int rdy_delay,
                         input logic keep_valid);
    int           n;
    int           ndrv;
    logic [1:0]   code;
    logic [W-1:0] qf;
    logic [W-1:0] ej, ek;
    predict(pred_q, mode, data, stuck0, qn_arm, n, code, qf);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = keep_valid;
    ndrv = 0;
    for (int c = 0; c < n * (S + 2); c++) begin
      if (c % (S + 2) == 0) begin
        ej = pj[c / (S + 2)];
        ek = pk[c / (S + 2)];
      end else begin
        ej = '0;
        ek = '0;
      end
      chk("jk_j", 32'(jk_j), 32'(ej));
      chk("jk_k", 32'(jk_k), 32'(ek));
      chk("rsp_valid_busy", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (c == 0) begin
        first_j = jk_j;
        first_k = jk_k;
      end
      if ((jk_j | jk_k) != '0) begin
        ndrv++;
        last_j = jk_j;
      end
      @(negedge clk);
    end
    for (int d = 0; d <= rdy_delay; d++) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_code", 32'(rsp_code), 32'(code));
      chk("rsp_q", 32'(rsp_q), 32'(qf));
      chk("jk_idle_j", 32'(jk_j), 32'd0);
      chk("jk_idle_k", 32'(jk_k), 32'd0);
      chk("cmd_ready_resp", 32'(cmd_ready), 32'd0);
      last_q    = rsp_q;
      last_code = rsp_code;
      if (d == rdy_delay) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    last_ndrv = ndrv;
    pred_q    = qf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bank_clr  = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 1'b0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    stuck0    = '0;
    qn_arm    = 1'b0;
    pred_q    = '0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_jk_j", 32'(jk_j), 32'd0);
    chk("reset_jk_k", 32'(jk_k), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_code", 32'(rsp_code), 32'd0);
    chk("reset_rsp_q", 32'(rsp_q), 32'd0);
    rst      = 1'b0;
    bank_clr = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // LOAD A5 from 00
    run_txn(1'b0, 8'hA5, 0, 1'b0);
    chk("t1_first_j", 32'(first_j), 32'hA5);
    chk("t1_first_k", 32'(first_k), 32'h00);
    chk("t1_rsp_q", 32'(last_q), 32'hA5);
    chk("t1_code", 32'(last_code), 32'd0);
    chk("t1_ndrv", 32'(last_ndrv), 32'd1);

    // TOGGLE 0F from A5
    run_txn(1'b1, 8'h0F, 0, 1'b0);
    chk("t2_first_j", 32'(first_j), 32'h0F);
    chk("t2_first_k", 32'(first_k), 32'h0F);
    chk("t2_rsp_q", 32'(last_q), 32'hAA);

    // bit 3 stuck at 0, LOAD FF: all retries used
    stuck0 = 8'h08;
    @(negedge clk);
    pred_q = pred_q & ~stuck0;
    run_txn(1'b0, 8'hFF, 0, 1'b0);
    chk("t3_code", 32'(last_code), 32'd1);
    chk("t3_rsp_q", 32'(last_q), 32'hF7);
    chk("t3_ndrv", 32'(last_ndrv), 32'(1 + MR));
    chk("t3_retry_j", 32'(last_j), 32'h08);
    stuck0 = '0;

    // Qn collapses onto Q after the drive
    qn_arm = 1'b1;
    run_txn(1'b0, 8'h00, 0, 1'b0);
    chk("t4_code", 32'(last_code), 32'd2);
    chk("t4_rsp_q", 32'(last_q), 32'h00);
    chk("t4_ndrv", 32'(last_ndrv), 32'd1);
    qn_arm = 1'b0;
    @(negedge clk);

    // response backpressure with a command waiting, then immediate accept
    run_txn(1'b0, 8'h5A, 5, 1'b1);
    run_txn(1'b1, 8'hFF, 0, 1'b0);
    chk("t5_rsp_q", 32'(last_q), 32'hA5);

    // zero toggle mask: nothing driven, passes first compare
    run_txn(1'b1, 8'h00, 0, 1'b0);
    chk("t5b_ndrv", 32'(last_ndrv), 32'd0);
    chk("t5b_rsp_q", 32'(last_q), 32'hA5);

    // reset during SETTLE
    chk("t6_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_mode  = 1'b0;
    cmd_data  = 8'h81;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_drive_j", 32'(jk_j), 32'h00);
    chk("t6_drive_k", 32'(jk_k), 32'h24);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_j", 32'(jk_j), 32'd0);
    chk("t6_rst_k", 32'(jk_k), 32'd0);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst    = 1'b0;
    pred_q = 8'h81;
    @(negedge clk);
    chk("t6_ready_again", 32'(cmd_ready), 32'd1);
    run_txn(1'b0, 8'h3C, 0, 1'b0);
    chk("t6_code", 32'(last_code), 32'd0);
    chk("t6_rsp_q", 32'(last_q), 32'h3C);

    // randomized commands, occasional stuck bit
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        stuck0 = 8'(1 << $urandom_range(0, 7));
        @(negedge clk);
        pred_q = pred_q & ~stuck0;
      end
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
      stuck0 = '0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
